// File: rtl/six_bit_seq_divider.sv
// Multi-cycle restoring divider for the Mini-ALU: one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
module six_bit_seq_divider #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             dvs_zero;
  logic             last_iter;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  logic [WIDTH-1:0] op_dvd;
  logic [WIDTH-1:0] op_dvs;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  assign accept    = (state == ST_IDLE) && start;
  assign dvs_zero  = (divisor == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Trial subtraction is one bit wider than the operands so the borrow lands in the MSB.
  always_comb begin
    shifted  = {prem[WIDTH-2:0], dvd_sh[WIDTH-1]};
    trial    = {1'b0, shifted} - {1'b0, dvs};
    borrow   = trial[WIDTH];
    prem_nxt = borrow ? shifted : trial[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], ~borrow};
  end

`ifdef SIGNED_DIV_EN
  logic signed [WIDTH-1:0] dvd_sgn;
  logic signed [WIDTH-1:0] dvs_sgn;
  logic                    neg_q;
  logic                    neg_r;
  logic                    ovf_pend;
  logic                    ovf_r;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? twos_neg(v) : v;
  endfunction

  assign dvd_sgn = $signed(dividend);
  assign dvs_sgn = $signed(divisor);
  assign op_dvd  = mag(dvd_sgn);
  assign op_dvs  = mag(dvs_sgn);
  assign res_q   = neg_q ? twos_neg(quo_nxt) : quo_nxt;
  assign res_r   = neg_r ? twos_neg(prem_nxt) : prem_nxt;

  // Sign fix-up flags ride alongside the unsigned core; the most-negative / -1 case wraps and is flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept) begin
      neg_q    <= (dvd_sgn < 0) ^ (dvs_sgn < 0);
      neg_r    <= (dvd_sgn < 0);
      ovf_pend <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
      ovf_r    <= 1'b0;
    end else if ((state == ST_DIV) && last_iter) begin
      ovf_r    <= ovf_pend;
    end
  end

  assign overflow = ovf_r;
`else
  assign op_dvd   = dividend;
  assign op_dvs   = divisor;
  assign res_q    = quo_nxt;
  assign res_r    = prem_nxt;
  assign overflow = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = dvs_zero ? ST_DONE : ST_DIV;
      end
      ST_DIV: begin
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dvd_sh      <= '0;
      dvs         <= '0;
      prem        <= '0;
      quo         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dvd_sh      <= op_dvd;
            dvs         <= op_dvs;
            prem        <= '0;
            quo         <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            // A zero divisor skips the core and publishes the fixed result immediately.
            if (dvs_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_DIV: begin
          dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
          prem   <= prem_nxt;
          quo    <= quo_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            quotient  <= res_q;
            remainder <= res_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_six_bit_seq_divider.sv
// Directed and randomized bench for six_bit_seq_divider against an arithmetic reference model.
module tb_six_bit_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] dividend = '0;
  logic [5:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  six_bit_seq_divider #(.WIDTH(6), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values, signed when the feature is built in.
  function automatic void model(input logic [5:0] a, input logic [5:0] b,
                                output logic [5:0] q, output logic [5:0] r,
                                output logic dz, output logic ov);
    int sa;
    int sb;
    int tq;
    int tr;
    logic [31:0] wq;
    logic [31:0] wr;
    sa = 0; sb = 0; tq = 0; tr = 0;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 6'd0) begin
      q  = 6'h3F;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      sa = $signed({{26{a[5]}}, a});
      sb = $signed({{26{b[5]}}, b});
      if (sa == -32 && sb == -1) begin
        tq = 32;
        tr = 0;
        ov = 1'b1;
      end else begin
        tq = sa / sb;
        tr = sa % sb;
      end
`else
      sa = int'(a);
      sb = int'(b);
      tq = sa / sb;
      tr = sa % sb;
`endif
      wq = tq;
      wr = tr;
      q  = wq[5:0];
      r  = wr[5:0];
    end
  endfunction

  task automatic do_div(input logic [5:0] a, input logic [5:0] b, input bit disturb, input string tag);
    logic [5:0] eq;
    logic [5:0] er;
    logic       ez;
    logic       eo;
    int         k;
    int         busy_cnt;
    int         exp_lat;
    model(a, b, eq, er, ez, eo);
    exp_lat = (b == 6'd0) ? 0 : 6;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (disturb && k == 2) begin
        start    = 1'b1;
        dividend = ~a;
        divisor  = 6'd0;
      end else if (disturb && k == 3) begin
        start    = 1'b0;
        dividend = 6'($urandom);
        divisor  = 6'($urandom);
      end
      tick();
      k++;
    end
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " busy_cycles"}, busy_cnt, exp_lat);
    chk({tag, " busy_at_done"}, busy, 1);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    chk({tag, " overflow"}, overflow, eo);
    if (disturb) start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " done_single"}, done, 0);
    chk({tag, " idle_after"}, busy, 0);
    chk({tag, " quotient_held"}, quotient, eq);
  endtask

  initial begin
    logic [5:0] ra;
    logic [5:0] rb;
    int saw_done;

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    do_div(6'd45, 6'd7, 1'b0, "45/7");
    do_div(6'd63, 6'd1, 1'b0, "63/1");
    do_div(6'd5, 6'd9, 1'b0, "5/9");
    do_div(6'd5, 6'd0, 1'b0, "5/0");
    do_div(6'd20, 6'd4, 1'b0, "20/4 after dbz");
    do_div(6'd40, 6'd3, 1'b1, "40/3 disturbed");

    // Abort 50/5 with reset partway through the iterations.
    start    = 1'b1;
    dividend = 6'd50;
    divisor  = 6'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    chk("abort overflow", overflow, 0);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (10) begin
      if (done === 1'b1) saw_done = 1;
      tick();
    end
    chk("abort no_done", saw_done, 0);
    do_div(6'd50, 6'd5, 1'b0, "50/5 after abort");

    do_div(6'd0, 6'd17, 1'b0, "0/17");
    do_div(6'd9, 6'd9, 1'b0, "9/9");
    do_div(6'h33, 6'd4, 1'b0, "h33/4");
    do_div(6'h20, 6'h3F, 1'b0, "h20/h3F");
    do_div(6'h20, 6'd1, 1'b0, "h20/1");

    for (int i = 0; i < 40; i++) begin
      ra = 6'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      do_div(ra, rb, 1'b0, "random");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/six_bit_seq_divider.md
Name: six_bit_seq_divider

Overview:
Multi-cycle 6-bit restoring divider for the Mini-ALU. It is the inverse-operation counterpart of the existing combinational add/subtract path.
- Computes one quotient bit per clock by trial subtraction of the divisor from a shifting partial remainder.
- Uses a start/busy/done handshake so the ALU controller can issue a divide and wait for the result.

Parameters:
WIDTH, 6, operand/quotient/remainder width; only 6 is verified
CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  request; sampled only in IDLE
dividend  input  6  numerator; captured on the accepting edge
divisor  input  6  denominator; captured on the accepting edge
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  6  result; held until next accepted start
remainder  output  6  result; held until next accepted start
div_by_zero  output  1  set with done when divisor == 0; held like quotient
overflow  output  1  signed overflow flag (see Optional Feature); 0 otherwise

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, counter=0, internal regs=0. Outputs quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, overflow=0. Reset overrides an operation in progress; no done is produced for the aborted operation.
- States: IDLE, DIV, DONE.
- IDLE: if start=1 at edge E0, capture operands and clear counter.
  - divisor != 0: go to DIV.
  - divisor == 0: go to DONE.
  - start=0: remain in IDLE.
- DIV, one iteration per edge E1..E6:
  - trial = {partial_rem[4:0], dividend_shift[5]} - divisor, computed in 7 bits so the borrow is visible.
  - No borrow: partial_rem = trial; shift 1 into quotient.
  - Borrow: partial_rem = shifted value (restore); shift 0 into quotient.
  - Counter increments each iteration. At the 6th iteration (counter==5), go to DONE.
- DONE: done=1 for exactly one cycle; quotient and remainder registered and valid; then go to IDLE on the next edge.
- Latency (normal): done is high in the cycle following edge E6, i.e. 6 cycles after the accepting edge.
- Latency (divide by zero): done is high in the cycle following edge E0.
- Divide-by-zero result: quotient=6'h3F, remainder=dividend, div_by_zero=1.
- Flag lifetime: div_by_zero and overflow are cleared on the next accepted start.
- start while busy (DIV or DONE): ignored, not queued. A new start is accepted only in IDLE, so the earliest back-to-back accept is the edge after the DONE cycle.
- Operands are registered at acceptance; later changes on dividend/divisor have no effect on the operation in flight.
- Unsigned build arithmetic: quotient = floor(dividend/divisor), remainder = dividend mod divisor, with 0 <= remainder < divisor.
- dividend < divisor gives quotient=0, remainder=dividend.
- dividend == 0 gives 0/0 with the full 6-cycle latency; there is no early exit.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - At acceptance, take magnitudes and run the same unsigned core.
  - In the DONE entry cycle, negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative, giving truncation toward zero.
  - Latency is unchanged.
  - -32 / -1: quotient=6'h20, remainder=0, overflow=1.
  - Divide by zero: same as the unsigned case.
- Undefined: unsigned only; overflow is tied to 0.

Test Plan:
- Reset, then 45/7 with start pulsed one cycle -> busy high 7 cycles; done high 6 cycles after the accepting edge; quotient=6, remainder=3; div_by_zero=0.
- 63/1, then 5/9 back-to-back, each start asserted in the first available IDLE cycle -> 63/0 then 0/5; no missed or duplicated done.
- 5/0 -> done in the cycle after acceptance; quotient=6'h3F, remainder=5, div_by_zero=1; next valid divide clears the flag.
- Start 40/3, pulse start again at iteration 3, and change the operand inputs mid-operation -> single done with quotient=13, remainder=1; the second start is ignored.
- Start 50/5, assert rst_n=0 at iteration 4 -> all outputs 0 the following cycle; no done pulse; a new 50/5 afterwards yields 10/0.
- SIGNED_DIV_EN defined:
  - -13/4 -> quotient=6'h3D, remainder=6'h3F.
  - -32/-1 -> quotient=6'h20, remainder=0, overflow=1.
